// File: rtl/alu_pkg.sv
// Shared definitions for the ALU add/sub datapath: operation encoding,
// lookahead group size and saturation bounds.
package alu_pkg;

  typedef enum logic [1:0] {
    ADD  = 2'b00,
    SUB  = 2'b01,
    SADD = 2'b10,
    SSUB = 2'b11
  } addsub_mode_t;

  localparam int CLA_GRP = 4;

  // Saturation bounds for a w-bit two's complement value, zero-extended to 64 bits.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/cla_chunk.sv
// Combinational W-bit carry-lookahead adder: 4-bit lookahead groups,
// group carries chained through group generate/propagate.
module cla_chunk
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  localparam int NG = W / CLA_GRP;

  logic [W-1:0] g, p, c;
  logic [NG:0]  gc;
  logic         t, gg, pg;

  assign g = a & b;
  assign p = a ^ b;

  // Each in-group carry is the flat sum-of-products of g/p and the group carry-in.
  always_comb begin
    c     = '0;
    gc    = '0;
    t     = 1'b0;
    gg    = 1'b0;
    pg    = 1'b0;
    gc[0] = cin;
    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j < CLA_GRP; j++) begin
        c[k*CLA_GRP+j] = gc[k];
        for (int m = 0; m < j; m++) c[k*CLA_GRP+j] = c[k*CLA_GRP+j] & p[k*CLA_GRP+m];
        for (int m = 0; m < j; m++) begin
          t = g[k*CLA_GRP+m];
          for (int n = m + 1; n < j; n++) t = t & p[k*CLA_GRP+n];
          c[k*CLA_GRP+j] = c[k*CLA_GRP+j] | t;
        end
      end
      gg = 1'b0;
      pg = 1'b1;
      for (int m = 0; m < CLA_GRP; m++) begin
        t = g[k*CLA_GRP+m];
        for (int n = m + 1; n < CLA_GRP; n++) t = t & p[k*CLA_GRP+n];
        gg = gg | t;
        pg = pg & p[k*CLA_GRP+m];
      end
      gc[k+1] = gg | (pg & gc[k]);
    end
  end

  assign sum   = p ^ c;
  assign cout  = gc[NG];
  assign c_msb = c[W-1];

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined CLA add/sub with optional saturation. Each stage adds one
// WIDTH/STAGES chunk; the whole pipe advances in lockstep under backpressure.
module cla_addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovfl,
  output logic [TAG_W-1:0] out_tag
);

  localparam int C = WIDTH / STAGES;
  localparam int L = STAGES - 1;

  if (STAGES < 1 || STAGES > 4 || WIDTH < CLA_GRP || WIDTH > 64 ||
      (WIDTH % (CLA_GRP * STAGES)) != 0 || TAG_W < 1) begin : g_bad_cfg
    $error("cla_addsub_pipe: unsupported WIDTH/STAGES/TAG_W combination");
  end

  addsub_mode_t op;
  logic         sub, sat, adv;
  logic [STAGES:0] vld_pipe;

  assign op          = addsub_mode_t'(mode);
  assign sub         = (op == SUB) || (op == SSUB);
  assign sat         = (op == SADD) || (op == SSUB);
  assign adv         = ~vld_pipe[STAGES] | out_ready;
  assign in_ready    = adv;
  assign vld_pipe[0] = in_valid;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int OW = WIDTH - k * C;  // operand bits still to be consumed
    localparam int RW = (k + 1) * C;    // result bits produced so far

    logic [OW-1:0]    opa, opb;
    logic             ci, sat_in, co, cm;
    logic [TAG_W-1:0] tag_in;
    logic [C-1:0]     s;
    logic [RW-1:0]    res_d;

    logic             vld_q, sat_q, cy_q;
    logic [TAG_W-1:0] tag_q;
    logic [RW-1:0]    res_q;

    if (k == 0) begin : g_in
      assign opa    = a;
      assign opb    = b ^ {WIDTH{sub}};
      assign ci     = sub;
      assign sat_in = sat;
      assign tag_in = in_tag;
      assign res_d  = s;
    end else begin : g_in
      assign opa    = stg[k-1].g_fwd.a_q;
      assign opb    = stg[k-1].g_fwd.b_q;
      assign ci     = stg[k-1].cy_q;
      assign sat_in = stg[k-1].sat_q;
      assign tag_in = stg[k-1].tag_q;
      assign res_d  = {s, stg[k-1].res_q};
    end

    cla_chunk #(.W(C)) u_cla (
      .a    (opa[C-1:0]),
      .b    (opb[C-1:0]),
      .cin  (ci),
      .sum  (s),
      .cout (co),
      .c_msb(cm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        sat_q <= 1'b0;
        cy_q  <= 1'b0;
        tag_q <= '0;
        res_q <= '0;
      end else if (adv) begin
        vld_q <= vld_pipe[k];
        sat_q <= sat_in;
        cy_q  <= co;
        tag_q <= tag_in;
        res_q <= res_d;
      end
    end

    assign vld_pipe[k+1] = vld_q;

    if (k < STAGES - 1) begin : g_fwd
      logic [OW-C-1:0] a_q, b_q;
      logic            cm_unused;
      assign cm_unused = cm;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= opa[OW-1:C];
          b_q <= opb[OW-1:C];
        end
      end
    end else begin : g_last
      // Signed overflow lives in the top chunk: carry into MSB differs from carry out.
      logic ov_q, sa_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ov_q <= 1'b0;
          sa_q <= 1'b0;
        end else if (adv) begin
          ov_q <= co ^ cm;
          sa_q <= opa[C-1];
        end
      end
    end
  end

  logic sat_hit;
  assign sat_hit   = stg[L].sat_q & stg[L].g_last.ov_q;
  assign sum       = sat_hit ? (stg[L].g_last.sa_q ? WIDTH'(sat_min(WIDTH)) : WIDTH'(sat_max(WIDTH)))
                             : stg[L].res_q;
  assign cout      = stg[L].cy_q;
  assign ovfl      = stg[L].g_last.ov_q;
  assign out_tag   = stg[L].tag_q;
  assign out_valid = vld_pipe[STAGES];

endmodule

// File: doc/cla_addsub_pipe.md
Name: cla_addsub_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath.
- Generalises the 16-bit combinational CLA add/sub in three ways:
  - configurable width and pipeline depth;
  - two extra saturating modes;
  - a valid/ready handshake with backpressure and a tag that travels with each operation.
- Sits between the decode/operand-fetch stage and ALU writeback.

Parameters:
- WIDTH, 16: operand/result width in bits; must be a multiple of 4 times STAGES.
- STAGES, 2: pipeline depth (1..4). Each stage adds one WIDTH/STAGES-bit chunk.
- TAG_W, 4: width of the sideband tag carried with each operation.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: operation offered.
- in_ready, output, 1: operation accepted when in_valid && in_ready at a rising edge.
- a, input, WIDTH: operand A, two's complement.
- b, input, WIDTH: operand B, two's complement.
- mode, input, 2: operation select. 00 ADD, 01 SUB, 10 SADD (saturating add), 11 SSUB (saturating subtract).
- in_tag, input, TAG_W: sideband tag, returned unchanged with the result.
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer accepts the result.
- sum, output, WIDTH: result.
- cout, output, 1: carry out of the MSB. For SUB/SSUB, 1 means no borrow.
- ovfl, output, 1: signed overflow of the unsaturated result.
- out_tag, output, TAG_W: tag of the current result.

Behaviour:
- Arithmetic:
  - ADD/SADD compute a + b + 0.
  - SUB/SSUB compute a + ~b + 1.
  - cout = carry out of bit WIDTH-1.
  - ovfl = (opA[MSB] == opB'[MSB]) && (raw[MSB] != opA[MSB]), where opB' is the inverted B for subtraction.
- Saturation (SADD/SSUB only), when ovfl = 1:
  - sum = 2^(WIDTH-1) - 1 if opA[MSB] = 0;
  - sum = -2^(WIDTH-1) otherwise.
  - ovfl and cout still report the raw values.
- ADD/SUB never saturate; sum is the raw result modulo 2^WIDTH.
- Pipeline structure:
  - Stage k (k = 0..STAGES-1) computes chunk k (bits k*C .. k*C+C-1, C = WIDTH/STAGES) using a CLA with 4-bit groups.
  - Stage k's carry-in is the registered carry from stage k-1; stage 0's carry-in is the subtract bit.
  - Operand chunks not yet consumed and result chunks already produced are delayed alongside the operation.
  - Saturation is applied combinationally from the last stage's registers.
- Latency: exactly STAGES cycles from acceptance to out_valid when there is no backpressure.
- Throughput: one operation per cycle.
- Handshake:
  - adv = ~out_valid | out_ready. Every stage register shifts together when adv = 1; no bubble collapsing.
  - in_ready = adv, purely combinational. A stage whose input slot is empty loads valid = 0.
  - When out_valid && !out_ready: all stages hold, and sum/cout/ovfl/out_tag stay stable.
  - out_valid must not drop until the result is taken.
- Simultaneous accept at input and consume at output in one cycle is legal and loses nothing.
- mode/a/b/in_tag are sampled only on acceptance; values while !in_valid are don't-care.
- Reset:
  - rst_n low clears all stage valid bits and data registers immediately.
  - out_valid = 0, sum = 0, cout = 0, ovfl = 0, out_tag = 0.
  - In-flight operations are discarded, including on a reset mid-operation.
  - in_ready = 1 during and after reset.
- STAGES = 1 degenerates to a single registered CLA stage.
- Out-of-range parameter combinations are caught by an elaboration-time assertion.

Decomposition:
- Package alu_pkg holds:
  - the addsub_mode_t enum (ADD, SUB, SADD, SSUB);
  - the CLA group size constant (4);
  - sat_max/sat_min functions parametrised on width.
- Sub-module cla_chunk (parameter W, default 4): combinational W-bit CLA taking a, b, cin and giving sum, cout, and an MSB carry-in for ovfl. It is instantiated once per stage.
- The top level holds the stage registers, handshake and saturation.

Test Plan (WIDTH=16, STAGES=2, out_ready=1 unless stated):
1. ADD a=0x1234, b=0x0001, tag=3 -> two cycles later out_valid=1, sum=0x1235, cout=0, ovfl=0, out_tag=3.
2. SUB a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovfl=0. Then SUB a=0x0007, b=0x0005 -> sum=0x0002, cout=1, ovfl=0.
3. ADD a=0x7FFF, b=0x0001 -> sum=0x8000, ovfl=1, cout=0. Next cycle, SADD with the same operands -> sum=0x7FFF, ovfl=1.
4. SUB a=0x8000, b=0x0001 -> sum=0x7FFF, ovfl=1, cout=1. SSUB with the same operands -> sum=0x8000, ovfl=1, cout=1. Cross-stage carry: ADD 0x00FF+0x0001 -> sum=0x0100.
5. Backpressure:
   - Stimulus: issue tags 0..3 back-to-back; drop out_ready for 3 cycles starting when tag 0 appears.
   - Required: in_ready=0 during the stall; tag 0's outputs are held stable.
   - Required: after out_ready returns, tags 0,1,2,3 emerge in order, one per cycle, none lost or duplicated.
6. Reset mid-flight: pull rst_n low asynchronously (between clock edges) while 2 operations are in the pipe.
   - out_valid=0 and sum=0 immediately.
   - After release, no output appears until a new operation is issued, which emerges after 2 cycles.
